ccc16_input_conditioner: RTL and testbench
==========================================

// Module: ccc16_input_conditioner
// PURPOSE
//  Front-end stage of the CCC16 capture/compare counter: conditions the asynchronous ext_in pin before
//  the counter/timer core. Synchronizes ext_in, rejects glitches shorter than a programmable length,
//  and emits single-cycle rise/fall/selected-event pulses. The core consumes evt (count mode) and
//  rise/fall (capture mode); the CFG glitch-length and event-select fields drive glth/evt_sel directly.
// PARAMETERS
//  SYNC_STAGES  2  flops in the ext_in synchronizer chain (>=2)
//  GLTH_W       4  width of glitch-length field and filter counter
// PORTS
//  clk      input   1        core clock
//  rst_n    input   1        asynchronous active-low reset
//  en       input   1        stage enable (CTRL counter-or-timer enable, ORed by the wrapper)
//  gf_en    input   1        glitch filter enable (CTRL.GFEN)
//  glth     input   GLTH_W   glitch filter length; new level must persist glth+1 cycles
//  evt_sel  input   2        00 none, 01 rising, 10 falling, 11 both edges
//  ext_in   input   1        raw asynchronous input pin
//  in_filt  output  1        conditioned level
//  rise     output  1        1-cycle pulse on in_filt 0->1
//  fall     output  1        1-cycle pulse on in_filt 1->0
//  evt      output  1        1-cycle pulse on the edge(s) chosen by evt_sel
// BEHAVIOUR
//  Reset (rst_n=0, async): sync chain, in_filt, filt_d, cnt all 0; rise/fall/evt = 0.
//  Sync: ext_in shifted through SYNC_STAGES flops every cycle regardless of en; s = last stage.
//  en=0: cnt<=0; in_filt<=s; filt_d<=s (same cycle) -> no edge pulse on enable; rise/fall/evt forced 0.
//  en=1, gf_en=0: in_filt<=s each cycle; cnt<=0.
//  en=1, gf_en=1 (filter): if s==in_filt: cnt<=0.
//    else if cnt>=glth: in_filt<=s, cnt<=0.   else cnt<=cnt+1.
//    -> s must differ from in_filt for glth+1 consecutive cycles; any return resets cnt.
//    glth=0 equals bypass timing; glth lowered below cnt mid-count -> update on next cycle (>= compare).
//    cnt never wraps: bounded by glth <= 2^GLTH_W-1.
//  Edge detect: filt_d<=in_filt every cycle (en=1). rise = en & in_filt & ~filt_d;
//    fall = en & ~in_filt & filt_d; evt = (evt_sel[0]&rise) | (evt_sel[1]&fall). Combinational from regs.
//  Latency (SYNC_STAGES=2): ext_in sampled high at edge k -> s high after edge k+1 ->
//    in_filt high after edge k+2+glth (gf_en=1) or k+2 (gf_en=0); rise/evt high for exactly that cycle.
//  Simultaneous: rise and fall never both 1. glth/evt_sel/gf_en changes take effect next edge,
//    no pulse generated by a config change alone. en dropped mid-count: count discarded, in_filt tracks s.
//  Reset mid-operation: all state cleared immediately; first post-reset edge needs full sync+filter time.
// TESTING
//  1 Reset: ext_in=1 held during rst_n=0 -> in_filt/rise/fall/evt=0; after release en=0 -> in_filt=1, no pulse.
//  2 Glitch reject: en=1,gf_en=1,glth=4,evt_sel=11; ext_in high 4 cycles -> in_filt stays 0, evt never 1.
//  3 Pass: glth=4, ext_in high 10 cycles -> in_filt rises 6 cycles after ext_in (2 sync+5 filter-1 edge
//    alignment per latency rule), rise=1 one cycle; fall=1 one cycle when low persists 5 cycles.
//  4 evt_sel: 01 -> evt only on rise; 10 -> only on fall; 00 -> evt never; 11 -> both; 3 pulses each case.
//  5 Bypass: gf_en=0, 1-cycle ext_in pulse aligned to clk -> in_filt high 1 cycle, rise then fall pulses.
//  6 Enable/reset mid-op: toggle en while ext_in=1 and cnt=2 -> no rise on re-enable; rst_n low mid-count
//    -> outputs 0 asynchronously, cnt restarts from 0.

Source files
------------

// File: rtl/ccc16_input_conditioner.sv
// Conditions the asynchronous ext_in pin: synchronizer, programmable glitch filter,
// and single-cycle rise/fall/selected-event pulses for the CCC16 counter core.
module ccc16_input_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GLTH_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              gf_en,
    input  logic [GLTH_W-1:0] glth,
    input  logic [1:0]        evt_sel,
    input  logic              ext_in,
    output logic              in_filt,
    output logic              rise,
    output logic              fall,
    output logic              evt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   in_filt_q, in_filt_d;
    logic                   filt_dly_q, filt_dly_d;
    logic [GLTH_W-1:0]      cnt_q, cnt_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state: synchronizer always shifts; filter and edge history depend on en/gf_en.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], ext_in};
        in_filt_d  = in_filt_q;
        filt_dly_d = in_filt_q;
        cnt_d      = '0;
        if (!en) begin
            // Load both level and history so enabling never produces a spurious edge.
            in_filt_d  = s;
            filt_dly_d = s;
        end else if (!gf_en) begin
            in_filt_d = s;
        end else if (s == in_filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= glth) begin
            in_filt_d = s;
        end else begin
            cnt_d = cnt_q + GLTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            in_filt_q  <= 1'b0;
            filt_dly_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            in_filt_q  <= in_filt_d;
            filt_dly_q <= filt_dly_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_filt = in_filt_q;
    assign rise    = en & in_filt_q & ~filt_dly_q;
    assign fall    = en & ~in_filt_q & filt_dly_q;
    assign evt     = (evt_sel[0] & rise) | (evt_sel[1] & fall);

endmodule

// File: tb/tb_ccc16_input_conditioner.sv
// Scoreboard bench for ccc16_input_conditioner: stimulus pushes expected pulses
// (cycle, rise, fall, evt, level); a monitor pops and compares whenever a pulse appears.
module tb_ccc16_input_conditioner;

    localparam int unsigned GLTH_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              gf_en;
    logic [GLTH_W-1:0] glth;
    logic [1:0]        evt_sel;
    logic              ext_in;
    logic              in_filt, rise, fall, evt;

    typedef struct {
        int   cyc;
        logic r;
        logic f;
        logic e;
        logic l;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   errors = 0;

    ccc16_input_conditioner #(.SYNC_STAGES(2), .GLTH_W(GLTH_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .gf_en   (gf_en),
        .glth    (glth),
        .evt_sel (evt_sel),
        .ext_in  (ext_in),
        .in_filt (in_filt),
        .rise    (rise),
        .fall    (fall),
        .evt     (evt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic r, input logic f, input logic l);
        exp_t x;
        x.cyc = at;
        x.r   = r;
        x.f   = f;
        x.e   = (evt_sel[0] & r) | (evt_sel[1] & f);
        x.l   = l;
        sb.push_back(x);
    endtask

    // High for 'width' cycles then low for 'low' cycles; 'lat' is the hand-derived
    // drive-to-observe latency (3 + effective glth), 'pass' whether the pulse survives.
    task automatic drive_pulse(input int width, input int low, input int lat, input bit pass);
        ext_in = 1'b1;
        if (pass) push(cyc + lat, 1'b1, 1'b0, 1'b1);
        repeat (width) @(negedge clk);
        ext_in = 1'b0;
        if (pass) push(cyc + lat, 1'b0, 1'b1, 1'b0);
        repeat (low) @(negedge clk);
    endtask

    // Monitor: sample mid-high-phase, away from both clock edges.
    always @(posedge clk) begin
        exp_t x;
        #3;
        if (rise | fall | evt) begin
            tests++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cyc %0d rise %0b fall %0b evt %0b expected none",
                         cyc, rise, fall, evt);
            end else begin
                x = sb.pop_front();
                if (x.cyc != cyc || x.r !== rise || x.f !== fall || x.e !== evt || x.l !== in_filt) begin
                    errors++;
                    $display("FAIL pulse: got cyc %0d r%0b f%0b e%0b l%0b expected cyc %0d r%0b f%0b e%0b l%0b",
                             cyc, rise, fall, evt, in_filt, x.cyc, x.r, x.f, x.e, x.l);
                end
            end
        end
    end

    initial begin
        int      c;
        int      r;
        logic [1:0] sels [4];
        sels[0] = 2'b01; sels[1] = 2'b10; sels[2] = 2'b00; sels[3] = 2'b11;

        rst_n = 1'b0; en = 1'b0; gf_en = 1'b0; glth = '0; evt_sel = 2'b00; ext_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_filt", int'(in_filt), 0);
        check("rst_rise",    int'(rise),    0);
        check("rst_fall",    int'(fall),    0);
        check("rst_evt",     int'(evt),     0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("en0_track_hi", int'(in_filt), 1);
        ext_in = 1'b0;
        repeat (5) @(negedge clk);
        check("en0_track_lo", int'(in_filt), 0);

        en = 1'b1; gf_en = 1'b1; glth = 4'd4; evt_sel = 2'b11;
        repeat (3) @(negedge clk);

        // Glitch of glth cycles is rejected; glth+1 cycles passes.
        drive_pulse(4, 8, 7, 1'b0);
        check("glitch_w4_level", int'(in_filt), 0);
        drive_pulse(5, 8, 7, 1'b1);
        drive_pulse(10, 10, 7, 1'b1);

        for (int i = 0; i < 4; i++) begin
            evt_sel = sels[i];
            @(negedge clk);
            for (int j = 0; j < 3; j++) drive_pulse(8, 8, 7, 1'b1);
        end

        // Bypass and glth=0 both give the bare synchronizer latency.
        gf_en = 1'b0;
        drive_pulse(1, 6, 3, 1'b1);
        drive_pulse(1, 6, 3, 1'b1);
        gf_en = 1'b1; glth = 4'd0;
        @(negedge clk);
        drive_pulse(1, 6, 3, 1'b1);

        // glth lowered below the running count mid-pulse: update on the next edge.
        glth = 4'd8;
        @(negedge clk);
        c = cyc;
        ext_in = 1'b1;
        push(c + 7, 1'b1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        glth = 4'd2;
        repeat (6) @(negedge clk);
        ext_in = 1'b0;
        push(cyc + 5, 1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk);

        // Enable dropped with cnt=2: level follows s, no rise on re-enable.
        glth = 4'd4;
        @(negedge clk);
        ext_in = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        repeat (8) @(negedge clk);
        check("en_toggle_level", int'(in_filt), 1);
        ext_in = 1'b0;
        push(cyc + 7, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        // Reset while counting toward a fall: async clear, then full sync+filter time.
        ext_in = 1'b1;
        push(cyc + 7, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        check("pre_reset_level", int'(in_filt), 1);
        ext_in = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_level", int'(in_filt), 0);
        check("async_rst_rise",  int'(rise),    0);
        check("async_rst_fall",  int'(fall),    0);
        check("async_rst_evt",   int'(evt),     0);
        ext_in = 1'b1;
        repeat (3) @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        push(r + 7, 1'b1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("post_rst_not_yet", int'(in_filt), 0);
        repeat (4) @(negedge clk);
        check("post_rst_level", int'(in_filt), 1);
        ext_in = 1'b0;
        push(cyc + 7, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
